mem_access_stage: RTL

//  Memory-access stage plus MEM/WB pipeline register, directly upstream of the write-back mux.

---
 rtl/mem_access_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage with MEM/WB pipeline register
// Optional feature macro: MISALIGN_TRAP_EN (adds the registered misalign output)
module mem_access_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] ex_alu_res,
  input  logic [WIDTH-1:0] ex_store_data,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_reg_write,
  input  logic [1:0]       ex_wbsel,
  input  logic [RD_W-1:0]  ex_rd,
  input  logic [WIDTH-1:0] ex_pcplus4,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic             stall,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [RD_W-1:0]  wb_rd,
  output logic [1:0]       wb_wbsel,
  output logic [WIDTH-1:0] wb_alu_res,
  output logic [WIDTH-1:0] wb_mem_data,
  output logic [WIDTH-1:0] wb_pcplus4
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misalign
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic             is_byte, is_half, mem_op, trap, bubble;
  logic [WIDTH-1:0] byte_sh, half_sh, load_val;

  assign is_byte = (ex_funct3[1:0] == 2'b00);
  assign is_half = (ex_funct3[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  assign trap = ex_valid & (ex_mem_read | ex_mem_write) &
                ((is_half & ex_alu_res[0]) | (~is_byte & ~is_half & (ex_alu_res[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  assign mem_op   = ex_valid & (ex_mem_read | ex_mem_write) & ~trap;
  // Reset must drop the request immediately even if upstream still presents a mem op.
  assign dmem_req = ~rst & ((state == WAIT) | mem_op);
  assign dmem_we  = dmem_req & ex_mem_write;
  assign stall    = dmem_req & ~dmem_ready;
  assign dmem_addr = {ex_alu_res[WIDTH-1:2], 2'b00};
  assign bubble   = stall | trap;

  always_comb begin
    dmem_wdata = ex_store_data;
    dmem_be    = 4'b0000;
    if (is_byte) begin
      dmem_wdata = {4{ex_store_data[7:0]}};
    end else if (is_half) begin
      dmem_wdata = {2{ex_store_data[15:0]}};
    end
    if (dmem_we) begin
      if (is_byte)      dmem_be = 4'b0001 << ex_alu_res[1:0];
      else if (is_half) dmem_be = 4'b0011 << {ex_alu_res[1], 1'b0};
      else              dmem_be = 4'b1111;
    end
  end

  // Funct3[2] selects zero extension; undefined sizes fall through as a full word.
  always_comb begin
    byte_sh  = dmem_rdata >> {ex_alu_res[1:0], 3'b000};
    half_sh  = dmem_rdata >> {ex_alu_res[1], 4'b0000};
    load_val = dmem_rdata;
    if (is_byte) begin
      load_val = {{(WIDTH-8){byte_sh[7] & ~ex_funct3[2]}}, byte_sh[7:0]};
    end else if (is_half) begin
      load_val = {{(WIDTH-16){half_sh[15] & ~ex_funct3[2]}}, half_sh[15:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_wbsel     <= '0;
      wb_alu_res   <= '0;
      wb_mem_data  <= '0;
      wb_pcplus4   <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (dmem_req && !dmem_ready) state <= WAIT;
        WAIT:    if (dmem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      wb_valid     <= ex_valid & ~bubble;
      wb_reg_write <= ex_valid & ex_reg_write & ~bubble;
      wb_rd        <= ex_rd;
      wb_wbsel     <= ex_wbsel;
      wb_alu_res   <= ex_alu_res;
      wb_pcplus4   <= ex_pcplus4;
      wb_mem_data  <= (ex_mem_read && dmem_req && dmem_ready) ? load_val : '0;
`ifdef MISALIGN_TRAP_EN
      misalign     <= trap;
`endif
    end
  end

endmodule
